// File: rtl/sobel_result_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sobel_pkg
// Description : Shared constants, FSM state type and baud helper for the
//               Sobel result UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package sobel_pkg;

    // Frame sync bytes that open every transfer
    localparam logic [7:0] SYNC0 = 8'hA5;
    localparam logic [7:0] SYNC1 = 8'h5A;

    // Number of header bytes preceding the pixel payload
    localparam int HDR_BYTES = 6;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        PIX  = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4
    } state_t;

    // Clocks per UART bit, rounded to nearest
    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + (baud / 2)) / baud;
    endfunction

endpackage : sobel_pkg
`default_nettype wire

// File: rtl/sobel_result_uart_tx_uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_byte
// Description : 8N1 byte serialiser with a valid/ready input. A byte is
//               captured on the handshake edge and its start bit is driven
//               from the following cycle, so back-to-back bytes leave no gap.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       tx,
    output logic       frame_done
);

    localparam int c_CW = $clog2(CLKS_PER_BIT);

    logic            r_active;
    logic [c_CW-1:0] r_cnt;
    logic [3:0]      r_bit;     // 0 = start, 1..8 = data, 9 = stop
    logic [7:0]      r_data;
    logic            r_tx;

    logic w_last;
    logic w_stop_end;

    assign w_last     = (r_cnt == c_CW'(CLKS_PER_BIT - 1));
    assign w_stop_end = r_active && (r_bit == 4'd9) && w_last;
    assign in_ready   = !r_active || w_stop_end;
    assign frame_done = w_stop_end;
    assign tx         = r_tx;

    // Bit timing and serialisation; a new byte may be taken on the last stop cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_bit    <= 4'd0;
            r_data   <= 8'h00;
            r_tx     <= 1'b1;
        end else if (in_valid && in_ready) begin
            r_active <= 1'b1;
            r_data   <= in_data;
            r_bit    <= 4'd0;
            r_cnt    <= '0;
            r_tx     <= 1'b0;
        end else if (r_active) begin
            if (w_last) begin
                r_cnt <= '0;
                if (r_bit == 4'd9) begin
                    r_active <= 1'b0;
                    r_tx     <= 1'b1;
                end else begin
                    r_bit <= r_bit + 4'd1;
                    r_tx  <= (r_bit == 4'd8) ? 1'b1 : r_data[r_bit[2:0]];
                end
            end else begin
                r_cnt <= r_cnt + c_CW'(1);
            end
        end
    end

endmodule : uart_tx_byte
`default_nettype wire

// File: rtl/sobel_result_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : sobel_result_uart_tx
// Description : Streams the Sobel output frame over UART: 6-byte header,
//               row-major pixels read from the output memory, then an 8-bit
//               additive checksum of the pixels.
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_result_uart_tx
    import sobel_pkg::*;
#(
    parameter int OUTW         = 238,
    parameter int OUTH         = 238,
    parameter int OUTTOT       = OUTW * OUTH,
    parameter int ADDR_W       = 16,
    parameter int CLKS_PER_BIT = calc_clks_per_bit(50_000_000, 115_200)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic [31:0]       bytes_sent
);

    localparam logic [15:0] c_OUTW16 = 16'(OUTW);
    localparam logic [15:0] c_OUTH16 = 16'(OUTH);

    state_t r_state;
    state_t w_state_nxt;

    logic [7:0]        r_hold;       // one-entry holding register feeding the shifter
    logic              r_hvld;
    logic [2:0]        r_hidx;       // header bytes staged so far
    logic              r_rd_en;
    logic              r_pend;       // read data arrives this cycle
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_rdcnt;      // pixel reads issued
    logic [31:0]       r_hcnt;       // pixels handed to the shifter
    logic              r_cs_staged;
    logic [7:0]        r_csum;
    logic [31:0]       r_bytes;

    logic       w_ready;
    logic       w_frame_done;
    logic       w_hs;
    logic       w_accept;
    logic       w_issue;
    logic [7:0] w_hdr_byte;

    assign w_hs     = r_hvld && w_ready;
    assign w_accept = ((r_state == IDLE) || (r_state == DONE)) && start;
    assign w_issue  = (r_state == PIX) && !r_hvld && !r_rd_en && !r_pend &&
                      (r_rdcnt < 32'(OUTTOT));

    assign mem_rd_en  = r_rd_en;
    assign mem_addr   = r_mem_addr;
    assign busy       = (r_state == HDR) || (r_state == PIX) || (r_state == CSUM);
    assign done       = (r_state == DONE);
    assign bytes_sent = r_bytes;

    // Header byte for the current staging index
    always_comb begin
        w_hdr_byte = 8'h00;
        case (r_hidx)
            3'd0:    w_hdr_byte = SYNC0;
            3'd1:    w_hdr_byte = SYNC1;
            3'd2:    w_hdr_byte = c_OUTW16[15:8];
            3'd3:    w_hdr_byte = c_OUTW16[7:0];
            3'd4:    w_hdr_byte = c_OUTH16[15:8];
            3'd5:    w_hdr_byte = c_OUTH16[7:0];
            default: w_hdr_byte = 8'h00;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: phases advance on the handshake of their last byte
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_state_nxt = HDR;
            HDR:  if (w_hs && (r_hidx == 3'(HDR_BYTES))) w_state_nxt = PIX;
            PIX:  if (w_hs && (r_hcnt == 32'(OUTTOT - 1))) w_state_nxt = CSUM;
            CSUM: if (w_frame_done && r_cs_staged && !r_hvld) w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Staging of header/pixel/checksum bytes, pixel prefetch, checksum and frame count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold      <= 8'h00;
            r_hvld      <= 1'b0;
            r_hidx      <= 3'd0;
            r_rd_en     <= 1'b0;
            r_pend      <= 1'b0;
            r_mem_addr  <= '0;
            r_rdcnt     <= 32'd0;
            r_hcnt      <= 32'd0;
            r_cs_staged <= 1'b0;
            r_csum      <= 8'h00;
            r_bytes     <= 32'd0;
        end else if (w_accept) begin
            r_hvld      <= 1'b0;
            r_hidx      <= 3'd0;
            r_rd_en     <= 1'b0;
            r_pend      <= 1'b0;
            r_rdcnt     <= 32'd0;
            r_hcnt      <= 32'd0;
            r_cs_staged <= 1'b0;
            r_csum      <= 8'h00;
            r_bytes     <= 32'd0;
        end else begin
            r_rd_en <= w_issue;
            r_pend  <= r_rd_en;
            if (w_issue) begin
                r_mem_addr <= r_rdcnt[ADDR_W-1:0];
                r_rdcnt    <= r_rdcnt + 32'd1;
            end
            if (w_hs) begin
                r_hvld <= 1'b0;
                if (r_state == PIX) begin
                    r_csum <= r_csum + r_hold;
                    r_hcnt <= r_hcnt + 32'd1;
                end
            end else if (r_pend) begin
                r_hold <= mem_rdata;
                r_hvld <= 1'b1;
            end else if ((r_state == HDR) && !r_hvld && (r_hidx < 3'(HDR_BYTES))) begin
                r_hold <= w_hdr_byte;
                r_hvld <= 1'b1;
                r_hidx <= r_hidx + 3'd1;
            end else if ((r_state == CSUM) && !r_hvld && !r_cs_staged) begin
                r_hold      <= r_csum;
                r_hvld      <= 1'b1;
                r_cs_staged <= 1'b1;
            end
            if (w_frame_done) begin
                r_bytes <= r_bytes + 32'd1;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (r_hvld),
        .in_ready   (w_ready),
        .in_data    (r_hold),
        .tx         (tx),
        .frame_done (w_frame_done)
    );

endmodule : sobel_result_uart_tx
`default_nettype wire

// File: tb/tb_sobel_result_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobel_result_uart_tx
// Description : Self-checking bench for sobel_result_uart_tx. Expected UART
//               waveform, status levels and decoded bytes come from a
//               byte-list model of the frame format.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sobel_result_uart_tx;

    localparam int W      = 4;
    localparam int H      = 3;
    localparam int N      = W * H;
    localparam int CPB    = 4;
    localparam int NBYTES = N + 7;
    localparam int FRAME  = 10 * CPB;
    localparam int XFER   = NBYTES * FRAME;
    localparam int LEN    = XFER + 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        tx;
    logic        busy;
    logic        done;
    logic [31:0] bytes_sent;

    logic [7:0]  mem [0:N-1];
    logic [15:0] addr_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  dec_q[$];
    logic        cap_tx   [LEN];
    logic        cap_busy [LEN];
    logic        cap_done [LEN];
    logic [31:0] cap_bs   [LEN];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sobel_result_uart_tx #(
        .OUTW         (W),
        .OUTH         (H),
        .ADDR_W       (16),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .tx         (tx),
        .busy       (busy),
        .done       (done),
        .bytes_sent (bytes_sent)
    );

    // 1-cycle latency memory with read-address log
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= mem[mem_addr[3:0]];
            addr_q.push_back(mem_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic build_expected();
        int sum;
        sum = 0;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'(W / 256));
        exp_q.push_back(8'(W % 256));
        exp_q.push_back(8'(H / 256));
        exp_q.push_back(8'(H % 256));
        for (int i = 0; i < N; i++) begin
            exp_q.push_back(mem[i]);
            sum += int'(mem[i]);
        end
        exp_q.push_back(8'(sum % 256));
    endtask

    // Line level k cycles after the accept edge
    function automatic logic exp_tx(input int k);
        int   j;
        int   b;
        logic [7:0] bv;
        if (k < 2 || k >= 2 + XFER) return 1'b1;
        j  = (k - 2) / CPB;
        bv = exp_q[j / 10];
        b  = j % 10;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return bv[b - 1];
    endfunction

    function automatic int exp_bs(input int k);
        int v;
        if (k < 2) return 0;
        v = (k - 2) / FRAME;
        return (v > NBYTES) ? NBYTES : v;
    endfunction

    // One transfer: pulse start, capture every cycle, compare against the model
    task automatic run_xfer(input string tag, input int poke_at);
        int   mism;
        int   i;
        logic [7:0] bv;
        addr_q.delete();
        dec_q.delete();
        build_expected();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < LEN; k++) begin
            cap_tx[k]   = tx;
            cap_busy[k] = busy;
            cap_done[k] = done;
            cap_bs[k]   = bytes_sent;
            start = (k == poke_at);
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " done_clr"}, 32'(cap_done[0]), 32'd0);
        check({tag, " busy_set"}, 32'(cap_busy[0]), 32'd1);
        mism = 0;
        for (int k = 0; k < LEN; k++) begin
            if (cap_tx[k] !== exp_tx(k)) mism++;
            if (cap_busy[k] !== (k < 2 + XFER)) mism++;
            if (cap_done[k] !== (k >= 2 + XFER)) mism++;
            if (cap_bs[k] !== 32'(exp_bs(k))) mism++;
        end
        check({tag, " wave_mism"}, 32'(mism), 32'd0);
        i = 0;
        while (i < LEN - FRAME && dec_q.size() < NBYTES) begin
            if (cap_tx[i] == 1'b0) begin
                for (int b = 0; b < 8; b++) bv[b] = cap_tx[i + CPB/2 + CPB*(b + 1)];
                dec_q.push_back(bv);
                i += FRAME;
            end else begin
                i++;
            end
        end
        check({tag, " nbytes"}, 32'(dec_q.size()), 32'(NBYTES));
        for (int b = 0; b < NBYTES && b < dec_q.size(); b++)
            check($sformatf("%s byte%0d", tag, b), 32'(dec_q[b]), 32'(exp_q[b]));
        check({tag, " bytes_sent"}, bytes_sent, 32'(NBYTES));
        check({tag, " done_end"}, 32'(done), 32'd1);
        check({tag, " busy_end"}, 32'(busy), 32'd0);
        check({tag, " tx_idle"}, 32'(tx), 32'd1);
        check({tag, " nreads"}, 32'(addr_q.size()), 32'(N));
        mism = 0;
        for (int a = 0; a < addr_q.size(); a++) if (addr_q[a] !== 16'(a)) mism++;
        check({tag, " addr_seq"}, 32'(mism), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst tx", 32'(tx), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst bytes", bytes_sent, 32'd0);
        check("rst rd_en", 32'(mem_rd_en), 32'd0);
        check("rst addr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Ramp image, then a repeat start from DONE
        for (int i = 0; i < N; i++) mem[i] = 8'(i);
        run_xfer("norm", -1);
        check("norm csum", 32'(dec_q[NBYTES-1]), 32'h42);
        run_xfer("again", -1);

        // Start pulsed mid-transfer is ignored
        run_xfer("busy_start", 100);

        // Reset in the middle of pixel 5's frame
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (2 + 11 * FRAME + 15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst tx", 32'(tx), 32'd1);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst bytes", bytes_sent, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        run_xfer("post_rst", -1);

        // Saturated image
        for (int i = 0; i < N; i++) mem[i] = 8'hFF;
        run_xfer("ff", -1);
        check("ff csum", 32'(dec_q[NBYTES-1]), 32'hF4);

        // Random images
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
            run_xfer($sformatf("rnd%0d", r), (r == 1) ? int'($urandom_range(3, XFER)) : -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sobel_result_uart_tx
`default_nettype wire
